// File: rtl/instr_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   fetch_state_t    : fetch FSM state encoding
//   PC_STEP          : byte increment between sequential fetches
//   RESET_PC_DEFAULT : default first fetch address after reset
package instr_prefetch_queue_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_REQ     = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_t;

  localparam int          PC_STEP          = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_prefetch_queue_fetch_fifo.sv
// fetch_fifo: synchronous FIFO holding {pc, instr} entries.
//   clk, rst            : clock, synchronous active-low reset
//   i_push, i_push_data : write an entry (ignored when full)
//   i_pop               : remove head (ignored when empty)
//   i_flush             : empty the FIFO; dominates push and pop
//   o_count             : current occupancy
//   o_head_valid/data   : head entry; data reads as zero when empty
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_head_valid,
  output logic [WIDTH-1:0]       o_head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok, w_pop_ok;

  assign w_push_ok = i_push & (r_count != CW'(DEPTH));
  assign w_pop_ok  = i_pop & (r_count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_count      = r_count;
  assign o_head_valid = (r_count != '0);
  // Gate with valid so the head reads as zero when empty (incl. after reset).
  assign o_head_data  = o_head_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: sequential instruction fetch front-end.
//   clk, rst                  : clock, synchronous active-low reset
//   mem_req/mem_addr          : registered fetch request, held until mem_ack
//   mem_ack/mem_rdata         : one-cycle completion pulse with returned word
//   if_valid/if_instr/if_pc   : FIFO head presented to the core
//   if_ready                  : core consumes head when if_valid=1
//   redirect/redirect_pc      : flush everything and restart at redirect_pc
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [DATA_WIDTH-1:0] if_pc,
  input  logic                  if_ready,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t            r_state;
  logic [DATA_WIDTH-1:0]   r_fetch_pc, r_mem_addr;
  logic                    r_mem_req;

  logic                    w_ack, w_pop, w_push, w_head_vld;
  logic [CW-1:0]           w_count, w_cnt_after;
  logic [2*DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0]   w_pc_inc, w_redir_pc;

  // Acks without an outstanding request are stray and ignored.
  assign w_ack       = mem_ack & r_mem_req;
  assign w_pop       = w_head_vld & if_ready;
  // Only words fetched in REQ are kept; DISCARD and redirect drop them.
  assign w_push      = w_ack & (r_state == FETCH_REQ) & ~redirect;
  assign w_cnt_after = w_count + CW'(w_push) - CW'(w_pop);
  assign w_pc_inc    = r_fetch_pc + DATA_WIDTH'(PC_STEP);
  assign w_redir_pc  = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

  fetch_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_data  ({r_fetch_pc, mem_rdata}),
    .i_pop        (w_pop),
    .i_flush      (redirect),
    .o_count      (w_count),
    .o_head_valid (w_head_vld),
    .o_head_data  (w_head)
  );

  // mem_addr tracks fetch_pc whenever no request is outstanding, so IDLE
  // always shows the next address. A new request is only issued when a FIFO
  // slot is free for its data, which keeps pushes from ever hitting a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= FETCH_IDLE;
      r_fetch_pc <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
    end else if (redirect) begin
      r_fetch_pc <= w_redir_pc;
      case (r_state)
        FETCH_REQ, FETCH_DISCARD: begin
          if (w_ack) begin
            // Request completed this edge: drop it and reissue at the target.
            r_state    <= FETCH_REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_redir_pc;
          end else begin
            // Must keep req/addr stable until the old fetch completes.
            r_state <= FETCH_DISCARD;
          end
        end
        default: r_mem_addr <= w_redir_pc;
      endcase
    end else begin
      case (r_state)
        FETCH_IDLE: begin
          if (w_count < DEPTH_C) begin
            r_state    <= FETCH_REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
          end
        end
        FETCH_REQ: begin
          if (w_ack) begin
            r_fetch_pc <= w_pc_inc;
            r_mem_addr <= w_pc_inc;
            if (w_cnt_after >= DEPTH_C) begin
              r_state   <= FETCH_IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        FETCH_DISCARD: begin
          if (w_ack) begin
            r_state    <= FETCH_REQ;
            r_mem_addr <= r_fetch_pc;
          end
        end
        default: begin
          r_state   <= FETCH_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign if_valid = w_head_vld;
  assign if_pc    = w_head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign if_instr = w_head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: a behavioural variable-latency
// memory, a delivery scoreboard, and one task per scenario.
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic        if_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  int n_vec = 0;
  int n_err = 0;
  int mem_lat = 1;
  bit mem_en = 1'b1;
  int wait_cnt = 0;
  int ack_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] m_exp;

  instr_prefetch_queue #(.DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [63:0] ent(input logic [31:0] a);
    return {a, instr_of(a)};
  endfunction

  // Memory: acks mem_lat cycles after seeing a request, one-cycle pulse.
  always @(posedge clk) begin
    #1;
    if (!mem_en) wait_cnt = 0;
    else if (mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_req) begin
      if (wait_cnt >= mem_lat - 1) begin
        mem_ack   = 1'b1;
        mem_rdata = instr_of(mem_addr);
        ack_cnt++;
        wait_cnt  = 0;
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  // Delivery scoreboard: every handshake must match the next expected entry.
  always @(negedge clk) begin
    if (rst && if_valid && if_ready && !redirect) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL deliver: got pc=%h instr=%h, none expected", if_pc, if_instr);
      end else begin
        m_exp = exp_q.pop_front();
        if ({if_pc, if_instr} !== m_exp) begin
          n_err++;
          $display("FAIL deliver: got pc=%h instr=%h, want pc=%h instr=%h",
                   if_pc, if_instr, m_exp[63:32], m_exp[31:0]);
        end
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b0; if_ready = 1'b0; redirect = 1'b0; mem_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ack_cnt = 0;
    exp_q.delete();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    mem_lat = 1;
    rst = 1'b0; if_ready = 1'b0; redirect = 1'b0; mem_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    n_vec++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h want 0", if_instr); end
    n_vec++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", if_pc); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", mem_req); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++; if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL first_req: got %b/%h want 1/0", mem_req, mem_addr); end
    @(posedge clk); #1;
    n_vec++; if ({if_valid, if_pc, if_instr} !== {1'b1, ent(32'h0)}) begin
      n_err++; $display("FAIL first_word: got %b/%h/%h want 1/0/%h", if_valid, if_pc, if_instr, instr_of(32'h0));
    end
  endtask

  task automatic test_sequential();
    mem_lat = 1;
    apply_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(32'(i * 4)));
    if_ready = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin @(posedge clk); #1; end
    if_ready = 1'b0;
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL seq_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    mem_lat = 1;
    apply_reset();
    repeat (20) @(posedge clk);
    #2;
    n_vec++; if (ack_cnt != 4) begin n_err++; $display("FAIL bp_acks: got %0d want 4", ack_cnt); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL bp_req: got %b want 0", mem_req); end
    n_vec++; if ({if_valid, if_pc} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL bp_head: got %b/%h want 1/0", if_valid, if_pc); end
    for (int i = 0; i < 6; i++) exp_q.push_back(ent(32'(i * 4)));
    if_ready = 1'b1;
    for (int c = 0; c < 80 && exp_q.size() != 0; c++) begin @(posedge clk); #1; end
    if_ready = 1'b0;
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_discard();
    bit found = 1'b0;
    mem_lat = 3;
    apply_reset();
    exp_q.push_back(ent(32'h0));   exp_q.push_back(ent(32'h4));
    exp_q.push_back(ent(32'h100)); exp_q.push_back(ent(32'h104));
    if_ready = 1'b1;
    for (int c = 0; c < 60 && !found; c++) begin
      @(posedge clk); #1;
      if (mem_req && mem_addr == 32'h8) found = 1'b1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL disc_req8: got no request want req for 00000008"); end
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h100;
    @(posedge clk); #1;
    redirect = 1'b0;
    n_vec++; if ({mem_req, mem_addr} !== {1'b1, 32'h8}) begin n_err++; $display("FAIL disc_hold: got %b/%h want 1/8", mem_req, mem_addr); end
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL disc_flush: got %b want 0", if_valid); end
    for (int c = 0; c < 80 && exp_q.size() != 0; c++) begin @(posedge clk); #1; end
    if_ready = 1'b0;
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL disc_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_pop_ack();
    bit found = 1'b0;
    mem_lat = 1;
    apply_reset();
    for (int c = 0; c < 30 && !found; c++) begin
      @(posedge clk); #2;
      if (mem_ack && if_valid) found = 1'b1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL pa_setup: got no ack+valid cycle want one"); end
    redirect = 1'b1; redirect_pc = 32'h203; if_ready = 1'b1;
    exp_q.push_back(ent(32'h200)); exp_q.push_back(ent(32'h204));
    @(posedge clk); #2;
    redirect = 1'b0;
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL pa_flush: got %b want 0", if_valid); end
    n_vec++; if ({mem_req, mem_addr} !== {1'b1, 32'h200}) begin n_err++; $display("FAIL pa_addr: got %b/%h want 1/200", mem_req, mem_addr); end
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin @(posedge clk); #1; end
    if_ready = 1'b0;
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL pa_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    mem_lat = 1;
    apply_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(posedge clk); #1;
    redirect = 1'b0;
    n_vec++; if ({mem_req, mem_addr} !== {1'b0, 32'hFFFF_FFF8}) begin n_err++; $display("FAIL wrap_idle: got %b/%h want 0/fffffff8", mem_req, mem_addr); end
    exp_q.push_back(ent(32'hFFFF_FFF8)); exp_q.push_back(ent(32'hFFFF_FFFC));
    exp_q.push_back(ent(32'h0000_0000));
    if_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin @(posedge clk); #1; end
    if_ready = 1'b0;
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL wrap_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    bit found = 1'b0;
    mem_lat = 3;
    apply_reset();
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk); #2;
      if (ack_cnt == 2 && !mem_ack) found = 1'b1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL mid_setup: got %0d acks want 2", ack_cnt); end
    n_vec++; if ({if_valid, mem_req, mem_addr} !== {1'b1, 1'b1, 32'h8}) begin
      n_err++; $display("FAIL mid_state: got %b/%b/%h want 1/1/8", if_valid, mem_req, mem_addr);
    end
    mem_en = 1'b0; rst = 1'b0;
    @(posedge clk); #2;
    n_vec++; if ({if_valid, mem_req, if_pc, mem_addr} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_err++; $display("FAIL mid_rst: got %b/%b/%h/%h want 0/0/0/0", if_valid, mem_req, if_pc, mem_addr);
    end
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #2;
    mem_ack = 1'b0;
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale: got %b want 0", if_valid); end
    n_vec++; if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL mid_refetch: got %b/%h want 1/0", mem_req, mem_addr); end
    exp_q.push_back(ent(32'h0)); exp_q.push_back(ent(32'h4));
    mem_en = 1'b1; if_ready = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin @(posedge clk); #1; end
    if_ready = 1'b0;
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL mid_drain: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_discard();
    test_redirect_pop_ack();
    test_wrap();
    test_reset_midflight();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
